pipe_hazard_ctl: RTL and testbench

//  Instruction-word pipeline for the 5-stage core: holds the IF/ID, ID/EX, EX/MEM and MEM/WB words.
//  The EX-stage forwarding unit decodes the ID/EX, EX/MEM and MEM/WB words.

---
 rtl/pipe_hazard_ctl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctl
//
// Instruction-word pipeline for the 5-stage core. It holds the IF/ID, ID/EX,
// EX/MEM and MEM/WB instruction words. The EX-stage forwarding unit decodes
// these words. This block also:
//   - detects load-use hazards that forwarding cannot cover. It then holds
//     the PC and IF/ID for one cycle and injects a bubble into ID/EX.
//   - squashes the word fetched behind a jump (the core has no delay slot).
//   - counts stall and flush cycles in saturating counters.
//
// Ports
//   clk         in   1      core clock, all state on the rising edge
//   rst         in   1      synchronous reset, active high
//   inst_in     in   32     word fetched at the current PC
//   inst_valid  in   1      inst_in is valid; when 0, NOP_WORD is captured
//   pc_en       out  1      PC may advance this cycle (combinational)
//   load_use    out  1      load-use stall this cycle (combinational)
//   flush       out  1      IF/ID squash this cycle (combinational)
//   if_id       out  32     IF/ID instruction word
//   id_ex       out  32     ID/EX instruction word
//   ex_mem      out  32     EX/MEM instruction word
//   mem_wb      out  32     MEM/WB instruction word
//   stall_cnt   out  CNT_W  cycles with load_use=1, saturating
//   flush_cnt   out  CNT_W  cycles with flush=1, saturating
//
// Handshake: there is no valid/ready pair. inst_valid qualifies inst_in on
// every cycle. pc_en tells fetch whether the word it presented was consumed.
// While pc_en=0, fetch must present the same word again on the next cycle.
// ---------------------------------------------------------------------------
module pipe_hazard_ctl #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter logic [5:0]  LW_OP    = 6'h23,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_in,
  input  logic             inst_valid,
  output logic             pc_en,
  output logic             load_use,
  output logic             flush,
  output logic [31:0]      if_id,
  output logic [31:0]      id_ex,
  output logic [31:0]      ex_mem,
  output logic [31:0]      mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      if_id_q,  if_id_d;
  logic [31:0]      id_ex_q,  id_ex_d;
  logic [31:0]      ex_mem_q, ex_mem_d;
  logic [31:0]      mem_wb_q, mem_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Field decode of the IF/ID word and the ID/EX word.
  logic [5:0] ifid_op;
  logic [4:0] ifid_rs, ifid_rt;
  logic [5:0] idex_op;
  logic [4:0] idex_rt;

  assign ifid_op = if_id_q[31:26];
  assign ifid_rs = if_id_q[25:21];
  assign ifid_rt = if_id_q[20:16];
  assign idex_op = id_ex_q[31:26];
  assign idex_rt = id_ex_q[20:16];

  logic uses_rt;
  logic is_jump;
  logic hazard;
  logic squash;

  // rt is a source operand only for R-type, store and the two branches.
  // For every other opcode rt is a destination and cannot create a hazard.
  assign uses_rt = (ifid_op == OP_RTYPE) || (ifid_op == OP_SW) ||
                   (ifid_op == OP_BEQ)   || (ifid_op == OP_BNE);

  // A load into $0 never creates a dependence. This gate also keeps the
  // bubbles (rs=rt=0) from matching each other.
  assign hazard = (idex_op == LW_OP) && (idex_rt != 5'd0) &&
                  ((ifid_rs == idex_rt) || (uses_rt && (ifid_rt == idex_rt)));

  assign is_jump = (ifid_op == OP_J) || (ifid_op == OP_JAL);

  // A stall takes priority. A jump held by a stall flushes on the next cycle.
  assign squash = is_jump && !hazard;

  always_comb begin
    mem_wb_d = ex_mem_q;
    ex_mem_d = id_ex_q;
    id_ex_d  = hazard ? NOP_WORD : if_id_q;

    if (hazard) begin
      if_id_d = if_id_q;
    end else if (squash) begin
      if_id_d = NOP_WORD;
    end else if (inst_valid) begin
      if_id_d = inst_in;
    end else begin
      if_id_d = NOP_WORD;
    end

    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    flush_cnt_d = flush_cnt_q;
    if (squash && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q     <= NOP_WORD;
      id_ex_q     <= NOP_WORD;
      ex_mem_q    <= NOP_WORD;
      mem_wb_q    <= NOP_WORD;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if_id_q     <= if_id_d;
      id_ex_q     <= id_ex_d;
      ex_mem_q    <= ex_mem_d;
      mem_wb_q    <= mem_wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign load_use  = hazard;
  assign flush     = squash;
  assign pc_en     = !hazard;
  assign if_id     = if_id_q;
  assign id_ex     = id_ex_q;
  assign ex_mem    = ex_mem_q;
  assign mem_wb    = mem_wb_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctl
//
// Directed bench for pipe_hazard_ctl. Each vector is driven 1 ns after a
// rising edge. Outputs are then sampled before the next edge. The expected
// values were worked out by hand from the instruction encodings below.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctl;

  localparam int CNT_W = 16;

  // Hand-assembled instruction words.
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD1  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] LW2   = 32'h8C22_0000; // lw  $2,0($1)
  localparam logic [31:0] ADD2  = 32'h0045_2020; // add $4,$2,$5  (needs $2 via rs)
  localparam logic [31:0] ADD3  = 32'h00C7_2020; // add $4,$6,$7  (independent)
  localparam logic [31:0] SW0   = 32'hAC00_0000; // sw  $0,0($0)
  localparam logic [31:0] LW0   = 32'h8C20_0000; // lw  $0,0($1)
  localparam logic [31:0] ADDI2 = 32'h2062_0001; // addi $2,$3,1 (rt is a destination)
  localparam logic [31:0] SW2   = 32'hAC62_0000; // sw  $2,0($3)  (needs $2 via rt)
  localparam logic [31:0] JMP   = 32'h0800_0010; // j 0x40
  localparam logic [31:0] JMP2  = 32'h0840_0010; // j with rs field = 2
  localparam logic [31:0] LW3   = 32'h8C43_0000; // lw  $3,0($2)
  localparam logic [31:0] ADD4  = 32'h0065_2020; // add $4,$3,$5

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]      inst_in    = '0;
  logic             inst_valid = 1'b0;
  logic             pc_en, load_use, flush;
  logic [31:0]      if_id, id_ex, ex_mem, mem_wb;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_in    (inst_in),
    .inst_valid (inst_valid),
    .pc_en      (pc_en),
    .load_use   (load_use),
    .flush      (flush),
    .if_id      (if_id),
    .id_ex      (id_ex),
    .ex_mem     (ex_mem),
    .mem_wb     (mem_wb),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Single checking point: counts the comparison and reports a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver: present one fetch word, then advance one edge and settle.
  task automatic cyc(input logic [31:0] w, input logic v);
    inst_in    = w;
    inst_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 1'b0);
  endtask

  initial begin
    // T1 reset with random fetch data.
    rst = 1'b1;
    cyc($urandom, 1'b1);
    cyc($urandom, 1'b1);
    check("rst_if_id",  if_id,  NOP);
    check("rst_id_ex",  id_ex,  NOP);
    check("rst_ex_mem", ex_mem, NOP);
    check("rst_mem_wb", mem_wb, NOP);
    check("rst_stall",  32'(stall_cnt), 32'd0);
    check("rst_flush",  32'(flush_cnt), 32'd0);
    check("rst_pc_en",  32'(pc_en),     32'd1);
    check("rst_lu",     32'(load_use),  32'd0);
    check("rst_fl",     32'(flush),     32'd0);
    rst = 1'b0;

    // T2 plain flow: the word moves one stage per cycle.
    cyc(ADD1, 1'b1);
    check("t2_if_id", if_id, ADD1);
    cyc(32'hFFFF_FFFF, 1'b0);
    check("t2_id_ex",   id_ex, ADD1);
    check("t2_invalid", if_id, NOP);
    cyc(32'h0, 1'b0);
    check("t2_ex_mem", ex_mem, ADD1);
    cyc(32'h0, 1'b0);
    check("t2_mem_wb", mem_wb, ADD1);

    // T3 load-use through rs: one stall, one bubble, fetch data ignored.
    cyc(LW2, 1'b1);
    check("t3_lu_pre", 32'(load_use), 32'd0);
    cyc(ADD2, 1'b1);
    check("t3_lu",    32'(load_use), 32'd1);
    check("t3_pc_en", 32'(pc_en),    32'd0);
    check("t3_fl",    32'(flush),    32'd0);
    cyc(32'h1111_1111, 1'b1);
    check("t3_hold",   if_id, ADD2);
    check("t3_bubble", id_ex, NOP);
    check("t3_ex_mem", ex_mem, LW2);
    check("t3_lu_off", 32'(load_use), 32'd0);
    check("t3_stall",  32'(stall_cnt), 32'd1);
    cyc(32'h0, 1'b0);
    check("t3_move", id_ex, ADD2);
    drain(3);

    // T4 loads that must not stall.
    cyc(LW2, 1'b1);
    cyc(ADD3, 1'b1);
    check("t4_indep_lu", 32'(load_use), 32'd0);
    cyc(32'h0, 1'b0);
    check("t4_no_bubble", id_ex, ADD3);
    cyc(LW2, 1'b1);
    cyc(SW0, 1'b1);
    check("t4_sw0_lu", 32'(load_use), 32'd0);
    cyc(LW0, 1'b1);
    cyc(32'h0, 1'b0);
    check("t4_rt0_lu", 32'(load_use), 32'd0);
    cyc(LW2, 1'b1);
    cyc(ADDI2, 1'b1);
    check("t4_addi_lu", 32'(load_use), 32'd0);
    // Store whose data register (rt) is the load target: stalls.
    cyc(LW2, 1'b1);
    cyc(SW2, 1'b1);
    check("t4_sw_rt_lu", 32'(load_use), 32'd1);
    cyc(32'h0, 1'b0);
    check("t4_sw_hold", if_id, SW2);
    check("t4_stall",   32'(stall_cnt), 32'd2);
    drain(4);

    // T5 jump squashes the word behind it.
    cyc(JMP, 1'b1);
    check("t5_flush", 32'(flush), 32'd1);
    check("t5_pc_en", 32'(pc_en), 32'd1);
    cyc(32'hDEAD_BEEF, 1'b1);
    check("t5_squash", if_id, NOP);
    check("t5_id_ex",  id_ex, JMP);
    check("t5_fl_off", 32'(flush), 32'd0);
    check("t5_fcnt",   32'(flush_cnt), 32'd1);
    cyc(32'h0, 1'b0);
    check("t5_no_dead", id_ex, NOP);
    drain(3);

    // T6 stall has priority over the jump; the flush follows once.
    cyc(LW2, 1'b1);
    cyc(JMP2, 1'b1);
    check("t6_lu",    32'(load_use), 32'd1);
    check("t6_fl0",   32'(flush),    32'd0);
    cyc(32'h1234_5678, 1'b1);
    check("t6_fl1",   32'(flush),    32'd1);
    check("t6_lu0",   32'(load_use), 32'd0);
    check("t6_hold",  if_id, JMP2);
    check("t6_stall", 32'(stall_cnt), 32'd3);
    cyc(32'h1234_5678, 1'b1);
    check("t6_fl2",   32'(flush), 32'd0);
    check("t6_sq",    if_id, NOP);
    check("t6_fcnt",  32'(flush_cnt), 32'd2);
    drain(3);

    // T7 back-to-back dependent loads stall independently.
    cyc(LW2, 1'b1);
    cyc(LW3, 1'b1);
    check("t7_lu_a", 32'(load_use), 32'd1);
    cyc(ADD4, 1'b1);
    check("t7_hold_a", if_id, LW3);
    check("t7_lu_off", 32'(load_use), 32'd0);
    cyc(ADD4, 1'b1);
    check("t7_lu_b", 32'(load_use), 32'd1);
    cyc(32'h0, 1'b0);
    check("t7_hold_b", if_id, ADD4);
    check("t7_bub_b",  id_ex, NOP);
    check("t7_stall",  32'(stall_cnt), 32'd5);
    drain(3);

    // T8 reset in the middle of a stall clears everything.
    cyc(LW2, 1'b1);
    cyc(ADD2, 1'b1);
    check("t8_lu", 32'(load_use), 32'd1);
    rst = 1'b1;
    cyc(32'hCAFE_F00D, 1'b1);
    check("t8_if_id", if_id, NOP);
    check("t8_ex_mem", ex_mem, NOP);
    check("t8_lu0",   32'(load_use),  32'd0);
    check("t8_stall", 32'(stall_cnt), 32'd0);
    check("t8_fcnt",  32'(flush_cnt), 32'd0);
    rst = 1'b0;
    cyc(ADD1, 1'b1);
    check("t8_resume", if_id, ADD1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
